// File: rtl/ln_result_stage.sv
// ln_result_stage: adds k*ln(2) to the scaled-operand ln and queues results; RESULT_SAT_EN selects saturation
module ln_result_stage #(
    parameter int DEPTH   = 4,
    parameter int LN2_Q12 = 2839
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [15:0]              y_i,
    input  logic [2:0]               shift_l_i,
    input  logic [2:0]               shift_r_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [15:0]              ln_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [17:0] LN2 = 18'(LN2_Q12);
    typedef enum logic [1:0] {IDLE, CORR, ADD, PUSH} state_t;
    state_t             state_q, state_d;
    logic signed [15:0] y_q, y_d;
    logic [2:0]         mag_q, mag_d;
    logic               neg_q, neg_d;
    logic signed [17:0] acc_q, acc_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [15:0]        res_q, res_d;
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]        count_q, count_d;
    logic               drop_q, drop_d;
    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic signed [3:0]  k;
    logic signed [17:0] sum;
    logic               pop, push;
    assign k       = signed'({1'b0, shift_r_i}) - signed'({1'b0, shift_l_i});
    assign sum     = 18'(y_q) + (neg_q ? -acc_q : acc_q);
    assign pop     = valid_o & ready_i;
    assign push    = (state_q == PUSH) && (count_q != (AW+1)'(DEPTH) || pop);
    assign valid_o = count_q != '0;
    assign ln_o    = valid_o ? mem_q[rd_q] : 16'h0000;
    assign busy_o  = state_q != IDLE;
    assign count_o = count_q;
    assign drop_o  = drop_q;
    // FSM, serial shift-add multiply, result reduction and FIFO bookkeeping
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        drop_d  = drop_q | (valid_i && state_q != IDLE);
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = (push && !pop) ? count_q + 1'b1 : (!push && pop) ? count_q - 1'b1 : count_q;
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = res_q;
        case (state_q)
            IDLE: if (valid_i) begin
                y_d     = signed'(y_i);
                neg_d   = k[3];
                mag_d   = k[3] ? 3'(-k) : k[2:0];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CORR;
            end
            CORR: begin
                acc_d   = acc_q + (mag_q[cnt_q] ? (LN2 <<< cnt_q) : 18'sd0);
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd2) ? ADD : CORR;
            end
            ADD: begin
`ifdef RESULT_SAT_EN
                res_d = (sum > 18'sd32767) ? 16'h7FFF : (sum < -18'sd32768) ? 16'h8000 : sum[15:0];
`else
                res_d = sum[15:0];
`endif
                state_d = PUSH;
            end
            default: state_d = push ? IDLE : PUSH;
        endcase
    end
    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_ln_result_stage.sv
// tb_ln_result_stage: scoreboard bench for ln_result_stage (honours RESULT_SAT_EN)
module tb_ln_result_stage;
    logic        clk = 1'b0;
    logic        rst, valid_i, ready_i;
    logic [15:0] y_i;
    logic [2:0]  shift_l_i, shift_r_i;
    logic        valid_o, busy_o, drop_o;
    logic [15:0] ln_o;
    logic [2:0]  count_o;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];

    ln_result_stage #(.DEPTH(4), .LN2_Q12(2839)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .y_i(y_i),
        .shift_l_i(shift_l_i), .shift_r_i(shift_r_i), .ready_i(ready_i),
        .valid_o(valid_o), .ln_o(ln_o), .busy_o(busy_o),
        .count_o(count_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare each popped head against the scoreboard
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none", ln_o);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (ln_o !== e) begin
                    errors++;
                    $display("FAIL ln_o: got 0x%0h expected 0x%0h", ln_o, e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] y, input logic [2:0] sl, input logic [2:0] sr,
                        input logic [15:0] e, input bit expect_it);
        y_i = y; shift_l_i = sl; shift_r_i = sr; valid_i = 1'b1;
        if (expect_it) exp_q.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic latency_check(input string name);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) chk({name, "_valid_n5"}, 32'(valid_o), 32'd0);
            if (i == 5) chk({name, "_valid_n6"}, 32'(valid_o), 32'd1);
        end
    endtask

    task automatic pop_all();
        int n;
        n = 0;
        ready_i = 1'b1;
        while (count_o != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ready_i = 1'b0;
        chk("drain_count", 32'(count_o), 32'd0);
    endtask

    logic [15:0] dy [6]  = '{16'h1000, 16'd32000, 16'hEC78, 16'h8AD0, 16'd100, 16'd1234};
    logic [2:0]  dl [6]  = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd3, 3'd2};
    logic [2:0]  dr [6]  = '{3'd3, 3'd7, 3'd0, 3'd0, 3'd3, 3'd5};
`ifdef RESULT_SAT_EN
    logic [15:0] de [6]  = '{16'h3145, 16'h7FFF, 16'h9ED7, 16'h8000, 16'h0064, 16'h2617};
`else
    logic [15:0] de [6]  = '{16'h3145, 16'hCAA1, 16'h9ED7, 16'h3D2F, 16'h0064, 16'h2617};
`endif
    logic [15:0] fe [5]  = '{16'h0000, 16'h0C17, 16'h182E, 16'h2445, 16'h305C};

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        y_i = '0; shift_l_i = '0; shift_r_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ln", 32'(ln_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single result, latency, head visible before pop
        send(16'h0000, 3'd1, 3'd0, 16'hF4E9, 1'b1);
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        latency_check("lat1");
        chk("head_ln", 32'(ln_o), 32'h0000F4E9);
        chk("count_one", 32'(count_o), 32'd1);
        pop_all();
        chk("empty_ln", 32'(ln_o), 32'd0);
        chk("empty_valid", 32'(valid_o), 32'd0);

        // directed arithmetic vectors, consumer always ready
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(dy[i], dl[i], dr[i], de[i], 1'b1);
            repeat (6) @(posedge clk);
            #1;
        end
        ready_i = 1'b0;
        chk("no_drop_yet", 32'(drop_o), 32'd0);

        // fill FIFO, hold in PUSH, drop while held, then push+pop
        for (int j = 0; j < 5; j++) begin
            send(16'(j * 256), 3'd0, 3'(j), fe[j], 1'b1);
            repeat (5) @(posedge clk);
        end
        #1;
        chk("full_count", 32'(count_o), 32'd4);
        chk("held_busy", 32'(busy_o), 32'd1);
        send(16'h0123, 3'd0, 3'd1, 16'h0000, 1'b0);
        chk("held_drop", 32'(drop_o), 32'd1);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk("pushpop_count", 32'(count_o), 32'd4);
        chk("released_busy", 32'(busy_o), 32'd0);
        pop_all();

        // reset during CORR discards in-flight and stored results
        send(16'h0200, 3'd0, 3'd0, 16'h0000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_count", 32'(count_o), 32'd1);
        send(16'h0300, 3'd0, 3'd2, 16'h0000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count_o), 32'd0);
        chk("async_valid", 32'(valid_o), 32'd0);
        chk("async_busy", 32'(busy_o), 32'd0);
        chk("async_drop", 32'(drop_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("no_ghost_write", 32'(count_o), 32'd0);
        send(16'h0000, 3'd1, 3'd0, 16'hF4E9, 1'b1);
        latency_check("lat_post_rst");
        pop_all();

        // re-assert two cycles after accept: second input dropped
        send(16'h0800, 3'd0, 3'd1, 16'h1317, 1'b1);
        @(posedge clk); #1;
        send(16'h4000, 3'd0, 3'd1, 16'h0000, 1'b0);
        chk("reassert_drop", 32'(drop_o), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("single_result", 32'(count_o), 32'd1);
        pop_all();
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
